// File: rtl/alarme_farol_pkg.sv
// rtl/alarme_farol_pkg.sv - shared state encoding and timing defaults for dashboard alarms
// Purpose : state enum for the headlight alarm FSM, default timing constants
//           reusable by other dashboard alarms, and a small sizing helper.
// Ports   : none (package).
package pkg_farol;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    BEEP_ON  = 3'd2,
    BEEP_OFF = 3'd3,
    HOLD     = 3'd4
  } estado_t;

  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_ON_CYC       = 3;
  localparam int DEF_OFF_CYC      = 2;
  localparam int DEF_MAX_BEEPS    = 3;

  // Largest of three phase lengths; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/alarme_farol_contador_ciclos.sv
// rtl/alarme_farol_contador_ciclos.sv - loadable up-counter with terminal-count flag
// Purpose : cycle counter shared by the DEBOUNCE / BEEP_ON / BEEP_OFF phases.
// Ports   : clk, reset (sync, active-high)
//           carga    - load valor this cycle (has priority over habilita)
//           valor    - load value
//           habilita - count up by one
//           limite   - terminal value compared against the current count
//           fim      - 1 while the count equals limite
module contador_ciclos
  import pkg_farol::*;
#(
  parameter int W = $clog2(max3(DEF_DEBOUNCE_CYC, DEF_ON_CYC, DEF_OFF_CYC))
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic [W-1:0] valor,
  input  logic         habilita,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (carga) begin
      cnt <= valor;
    end else if (habilita) begin
      cnt <= cnt + W'(1);
    end
  end

  assign fim = (cnt == limite);

endmodule

// File: rtl/alarme_farol.sv
// rtl/alarme_farol.sv - headlight-left-on audible alarm (debounce, beep pattern, mute)
// Purpose : turns the indicator level into a bounded beep pattern on the buzzer,
//           with debounce of the indicator and a driver mute.
// Ports   : clk, reset (sync, active-high)
//           sinalizador  - indicator level (1 = headlight left on)
//           silenciar    - driver mute request
//           buzzer       - buzzer drive, 1 = sound
//           alarme_ativo - alarm confirmed (beeping or silenced hold)
//           num_beeps    - completed beeps in the current episode
module alarme_farol
  import pkg_farol::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int ON_CYC       = DEF_ON_CYC,
  parameter int OFF_CYC      = DEF_OFF_CYC,
  parameter int MAX_BEEPS    = DEF_MAX_BEEPS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sinalizador,
  input  logic       silenciar,
  output logic       buzzer,
  output logic       alarme_ativo,
  output logic [2:0] num_beeps
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYC, ON_CYC, OFF_CYC));

  estado_t       estado;
  logic [2:0]    beeps;
  logic          carga;
  logic [CW-1:0] valor;
  logic          habilita;
  logic [CW-1:0] limite;
  logic          fim;
  logic          ultimo_beep;

  // Terminal value of the shared counter depends on the current phase.
  always_comb begin
    limite = '0;
    case (estado)
      DEBOUNCE: limite = CW'(DEBOUNCE_CYC - 1);
      BEEP_ON:  limite = CW'(ON_CYC - 1);
      BEEP_OFF: limite = CW'(OFF_CYC - 1);
      default:  limite = '0;
    endcase
  end

  // Counter control: keep counting while a timed phase continues, otherwise
  // reload. IDLE loads 1 because the first edge seeing the indicator already
  // counts as a debounce cycle.
  always_comb begin
    carga    = 1'b1;
    valor    = '0;
    habilita = 1'b0;
    if (sinalizador) begin
      case (estado)
        IDLE: valor = CW'(1);
        DEBOUNCE, BEEP_ON, BEEP_OFF: begin
          if (!silenciar && !fim) begin
            carga    = 1'b0;
            habilita = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  contador_ciclos #(.W(CW)) u_contador (
    .clk      (clk),
    .reset    (reset),
    .carga    (carga),
    .valor    (valor),
    .habilita (habilita),
    .limite   (limite),
    .fim      (fim)
  );

  assign ultimo_beep = (beeps == 3'(MAX_BEEPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= IDLE;
      beeps  <= 3'd0;
    end else if (!sinalizador) begin
      estado <= IDLE;
      beeps  <= 3'd0;
    end else begin
      case (estado)
        IDLE: estado <= DEBOUNCE;
        DEBOUNCE: begin
          if (silenciar) estado <= HOLD;
          else if (fim)  estado <= BEEP_ON;
        end
        BEEP_ON: begin
          if (fim) begin
            // A mute on the final ON cycle still counts the beep.
            beeps <= beeps + 3'd1;
            if (ultimo_beep || silenciar) estado <= HOLD;
            else                          estado <= BEEP_OFF;
          end else if (silenciar) begin
            estado <= HOLD;
          end
        end
        BEEP_OFF: begin
          if (silenciar) estado <= HOLD;
          else if (fim)  estado <= BEEP_ON;
        end
        HOLD: estado <= HOLD;
        default: begin
          estado <= IDLE;
          beeps  <= 3'd0;
        end
      endcase
    end
  end

  assign buzzer       = (estado == BEEP_ON);
  assign alarme_ativo = (estado == BEEP_ON) || (estado == BEEP_OFF) || (estado == HOLD);
  assign num_beeps    = beeps;

endmodule

// File: tb/tb_alarme_farol.sv
// tb/tb_alarme_farol.sv - scoreboard bench for alarme_farol
module tb_alarme_farol;

  localparam int D   = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int MAX = 3;
  localparam int P   = ON + OFF;

  logic       clk;
  logic       reset;
  logic       sinalizador;
  logic       silenciar;
  logic       buzzer;
  logic       alarme_ativo;
  logic [2:0] num_beeps;

  alarme_farol #(
    .DEBOUNCE_CYC (D),
    .ON_CYC       (ON),
    .OFF_CYC      (OFF),
    .MAX_BEEPS    (MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sinalizador  (sinalizador),
    .silenciar    (silenciar),
    .buzzer       (buzzer),
    .alarme_ativo (alarme_ativo),
    .num_beeps    (num_beeps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       buz;
    logic       atv;
    logic [2:0] nb;
  } exp_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;
  int   ciclo  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, ciclo, obs, expv);
    end
  endtask

  // Reference model in time-since-alarm terms: streak of consecutive
  // indicator samples, elapsed alarm time t, and a frozen mute snapshot.
  int m_streak = 0;
  int m_t      = 0;
  int m_frozen = 0;
  bit m_muted  = 0;

  function automatic int completed(input int tt);
    int n = 0;
    for (int k = 0; k < MAX; k++)
      if (k * P + ON <= tt) n++;
    return n;
  endfunction

  task automatic model(input bit r, input bit s, input bit m, output exp_t e);
    if (r || !s) begin
      m_streak = 0; m_t = 0; m_muted = 0; m_frozen = 0;
    end else if (m_muted) begin
    end else if (m_streak == 0) begin
      m_streak = 1;
    end else if (m_streak < D) begin
      if (m) begin m_muted = 1; m_frozen = 0; end
      else m_streak++;
    end else begin
      if (m && m_t < (MAX - 1) * P + ON) begin
        m_muted  = 1;
        m_frozen = completed(m_t) + ((m_t % P == ON - 1) ? 1 : 0);
      end else begin
        m_t++;
      end
    end
    if (m_muted) begin
      e.buz = 1'b0; e.atv = 1'b1; e.nb = 3'(m_frozen);
    end else if (m_streak < D) begin
      e.buz = 1'b0; e.atv = 1'b0; e.nb = 3'd0;
    end else begin
      e.buz = ((m_t % P) < ON) && ((m_t / P) < MAX);
      e.atv = 1'b1;
      e.nb  = 3'(completed(m_t));
    end
  endtask

  task automatic step(input bit r, input bit s, input bit m);
    exp_t e;
    reset       = r;
    sinalizador = s;
    silenciar   = m;
    model(r, s, m, e);
    q_exp.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold_sin(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #2;
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      ciclo++;
      chk("buzzer", 32'(buzzer), 32'(e.buz));
      chk("alarme_ativo", 32'(alarme_ativo), 32'(e.atv));
      chk("num_beeps", 32'(num_beeps), 32'(e.nb));
    end
  end

  initial begin
    reset = 1'b1; sinalizador = 1'b0; silenciar = 1'b0;
    // reset state and full beep pattern
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    hold_sin(25);
    idle(2);
    // glitchy indicator never completes debounce
    hold_sin(3); idle(1); hold_sin(3); idle(2);
    // silence in BEEP_OFF after first beep, then release
    hold_sin(7); step(1'b0, 1'b1, 1'b1); hold_sin(4); idle(2);
    // drop during second cycle of second beep, then fresh debounce
    hold_sin(10); idle(1); hold_sin(8); idle(2);
    // reset during BEEP_ON
    hold_sin(5); step(1'b1, 1'b1, 1'b0); hold_sin(8); idle(2);
    // mute together with indicator drop goes to IDLE
    hold_sin(6); step(1'b0, 1'b0, 1'b1); idle(2);
    // mute on final ON cycle still counts the beep
    hold_sin(6); step(1'b0, 1'b1, 1'b1); hold_sin(3); idle(1);
    // mute ignored in IDLE, mute during debounce, mute in HOLD
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b1); hold_sin(1);
    step(1'b0, 1'b1, 1'b1); hold_sin(3); idle(1);
    hold_sin(20); step(1'b0, 1'b1, 1'b1); hold_sin(2); idle(1);
    // random mix
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 14) == 0);
    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
